key_decoder: RTL and testbench

Scan-frame decoder for the 4x4 keypad. Consumes the per-cycle row/column word produced by the column-scan stage, assembles four consecutive columns into a 16-key press map, debounces over whole scan frames, and emits one hex key code per accepted press with a single-cycle strobe. Sits between the scan stage and the display/control logic.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/scan_frame_assembler.sv | 57 +++++
 rtl/key_decoder.sv | 118 +++++++++++
 tb/tb_key_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key legend and helpers for the 4x4 keypad decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } kd_state_t;

    localparam logic [3:0] COL_FIRST = 4'b1000;
    localparam logic [3:0] COL_LAST  = 4'b0001;

    // Indexed by raw 4*row+col; the pad legend is wired transposed to the scan matrix.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'hD, 4'hC, 4'hB, 4'hA,
        4'hF, 4'h9, 4'h6, 4'h3,
        4'h0, 4'h8, 4'h5, 4'h2,
        4'hE, 4'h7, 4'h4, 4'h1
    };

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(m[i]);
        return n;
    endfunction

    function automatic logic onehot4(input logic [3:0] c);
        return (c != 4'b0) && ((c & (c - 4'd1)) == 4'b0);
    endfunction

    function automatic logic [3:0] low_index16(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_frame_assembler.sv
// Collects four ordered column words into one 16-bit key map.
module scan_frame_assembler
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rcbits,
    output logic [15:0] frame_map,
    output logic        frame_done
);

    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] spread;
    logic [15:0] acc;
    logic [3:0]  expect_col;
    logic        active;

    assign row = rcbits[7:4];
    assign col = rcbits[3:0];

    always_comb begin
        spread = '0;
        for (int r = 0; r < 4; r++) begin
            spread[4*r +: 4] = row[r] ? col : 4'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            expect_col <= '0;
            active     <= 1'b0;
            frame_map  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (col == COL_FIRST) begin
                acc        <= spread;
                expect_col <= COL_FIRST >> 1;
                active     <= 1'b1;
            end else if (active && onehot4(col) && col == expect_col) begin
                if (col == COL_LAST) begin
                    frame_map  <= acc | spread;
                    frame_done <= 1'b1;
                    active     <= 1'b0;
                end else begin
                    acc        <= acc | spread;
                    expect_col <= expect_col >> 1;
                end
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_decoder.sv
// Frame-level debounce FSM producing one hex code per accepted key press.
module key_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rcbits,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

    logic [15:0] frame_map;
    logic        frame_done;
    logic [4:0]  pc;
    logic        is_none;
    logic        is_single;
    logic [3:0]  idx;
    logic [3:0]  cnt_inc;

    kd_state_t   state;
    logic [3:0]  cand;
    logic [3:0]  cnt;

    scan_frame_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .rcbits     (rcbits),
        .frame_map  (frame_map),
        .frame_done (frame_done)
    );

    assign pc        = popcount16(frame_map);
    assign is_none   = (pc == 5'd0);
    assign is_single = (pc == 5'd1);
    assign idx       = low_index16(frame_map);
    assign cnt_inc   = cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_done) begin
                unique case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand <= idx;
                            cnt  <= 4'd1;
                            if (DF == 4'd1) begin
                                key       <= KEY_MAP[idx];
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                state     <= HELD;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (is_single && idx == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DF) begin
                                key       <= KEY_MAP[cand];
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                state     <= HELD;
                            end
                        end else if (is_single) begin
                            cand <= idx;
                            cnt  <= 4'd1;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (is_none) begin
                            if (DF == 4'd1) begin
                                cnt      <= '0;
                                key_down <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                cnt   <= 4'd1;
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (is_none) begin
                            if (cnt_inc == DF) begin
                                cnt      <= '0;
                                key_down <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= HELD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_decoder.sv
// Randomized and directed bench for key_decoder (debounce 4 and debounce 1 builds).
module tb_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rcbits;
    logic [3:0] key0, key1;
    logic       key_valid0, key_valid1;
    logic       key_down0, key_down1;

    int n_pass  = 0;
    int n_total = 0;

    // Hex legend by raw 4*row+col
    bit [3:0] legend [16] = '{
        4'hD, 4'hC, 4'hB, 4'hA, 4'hF, 4'h9, 4'h6, 4'h3,
        4'h0, 4'h8, 4'h5, 4'h2, 4'hE, 4'h7, 4'h4, 4'h1
    };

    int       dfr [2] = '{4, 1};
    int       run_idx [2];
    int       run_len [2];
    int       none_run [2];
    bit       down [2];
    bit [3:0] model_key [2];
    bit       pend_valid [2];
    int       pulses [2];

    int        trk_pos;
    bit [15:0] trk_map;

    key_decoder #(.DEBOUNCE_FRAMES(4)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .rcbits    (rcbits),
        .key       (key0),
        .key_valid (key_valid0),
        .key_down  (key_down0)
    );

    key_decoder #(.DEBOUNCE_FRAMES(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .rcbits    (rcbits),
        .key       (key1),
        .key_valid (key_valid1),
        .key_down  (key_down1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit [15:0] kbit(input int r);
        bit [15:0] m;
        m = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            run_idx[m]    = 0;
            run_len[m]    = 0;
            none_run[m]   = 0;
            down[m]       = 0;
            model_key[m]  = '0;
            pend_valid[m] = 0;
            pulses[m]     = 0;
        end
        trk_pos = 0;
        trk_map = '0;
    endtask

    // Press accepted after D identical single-key frames while up;
    // released after D empty frames while down.
    task automatic model_frame(input bit [15:0] fm);
        int n;
        int ix;
        n  = $countones(fm);
        ix = 0;
        for (int i = 0; i < 16; i++) if (fm[i]) ix = i;
        for (int m = 0; m < 2; m++) begin
            if (n == 1) begin
                if (run_len[m] > 0 && run_idx[m] == ix) run_len[m]++;
                else begin
                    run_idx[m] = ix;
                    run_len[m] = 1;
                end
                none_run[m] = 0;
            end else if (n == 0) begin
                run_len[m] = 0;
                none_run[m]++;
            end else begin
                run_len[m]  = 0;
                none_run[m] = 0;
            end
            if (!down[m] && n == 1 && run_len[m] == dfr[m]) begin
                down[m]       = 1;
                model_key[m]  = legend[ix];
                pend_valid[m] = 1;
            end else if (down[m] && n == 0 && none_run[m] == dfr[m]) begin
                down[m] = 0;
            end
        end
    endtask

    task automatic track(input logic [7:0] w);
        logic [3:0] col;
        logic [3:0] rows;
        logic [3:0] want;
        bit         take;
        col  = w[3:0];
        rows = w[7:4];
        want = 4'b1000 >> trk_pos;
        take = 0;
        if (col == 4'b1000) begin
            trk_map = '0;
            trk_pos = 0;
            take    = 1;
        end else if (trk_pos > 0 && col == want) begin
            take = 1;
        end else begin
            trk_pos = 0;
        end
        if (take) begin
            for (int cb = 0; cb < 4; cb++)
                for (int r = 0; r < 4; r++)
                    if (col[cb] && rows[r]) trk_map[4*r+cb] = 1'b1;
            if (trk_pos == 3) begin
                trk_pos = 0;
                model_frame(trk_map);
            end else begin
                trk_pos++;
            end
        end
    endtask

    task automatic send(input logic [7:0] w);
        logic [3:0] k;
        logic       v;
        logic       d;
        rcbits = w;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            k = (m == 0) ? key0 : key1;
            v = (m == 0) ? key_valid0 : key_valid1;
            d = (m == 0) ? key_down0 : key_down1;
            chk($sformatf("i%0d_valid", m), 8'(v), 8'(pend_valid[m]));
            chk($sformatf("i%0d_key", m), 8'(k), 8'(model_key[m]));
            chk($sformatf("i%0d_down", m), 8'(d), 8'(down[m]));
            if (v) pulses[m]++;
            pend_valid[m] = 0;
        end
        track(w);
    endtask

    task automatic send_frame(input bit [15:0] fm);
        logic [3:0] rows;
        logic [3:0] col;
        for (int p = 0; p < 4; p++) begin
            col = 4'b1000 >> p;
            for (int r = 0; r < 4; r++) rows[r] = fm[4*r + 3 - p];
            send({rows, col});
        end
    endtask

    task automatic frames(input bit [15:0] fm, input int n);
        for (int i = 0; i < n; i++) send_frame(fm);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        rcbits = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rst_key0", 8'(key0), 8'h0);
        chk("rst_valid0", 8'(key_valid0), 8'h0);
        chk("rst_down0", 8'(key_down0), 8'h0);
        chk("rst_key1", 8'(key1), 8'h0);
        chk("rst_down1", 8'(key_down1), 8'h0);
    endtask

    initial begin
        bit [15:0] fm;
        int        sel;
        int        hold;
        reset  = 1'b1;
        rcbits = 8'h00;
        model_clear();
        do_reset();

        frames(kbit(9), 4);
        send(8'h00);
        chk("t1_pulses", 8'(pulses[0]), 8'd1);
        chk("t1_key", 8'(key0), 8'h8);
        chk("t1_down", 8'(key_down0), 8'd1);

        pulses[0] = 0;
        frames(16'h0, 3);
        frames(kbit(5), 1);
        frames(16'h0, 3);
        chk("t2_still_down", 8'(key_down0), 8'd1);
        frames(16'h0, 1);
        send(8'h00);
        chk("t2_pulses", 8'(pulses[0]), 8'd0);
        chk("t2_down", 8'(key_down0), 8'd0);

        do_reset();
        frames(kbit(0), 2);
        frames(16'h0, 1);
        frames(kbit(0), 4);
        send(8'h00);
        chk("t3_pulses", 8'(pulses[0]), 8'd1);
        chk("t3_key", 8'(key0), 8'hD);

        do_reset();
        frames(kbit(15) | kbit(12), 10);
        send(8'h00);
        chk("t4_multi_pulses", 8'(pulses[0]), 8'd0);
        chk("t4_multi_down", 8'(key_down0), 8'd0);

        do_reset();
        frames(kbit(15), 2);
        frames(kbit(3), 3);
        send(8'h00);
        chk("t4_sw_early", 8'(pulses[0]), 8'd0);
        frames(kbit(3), 1);
        send(8'h00);
        chk("t4_sw_pulses", 8'(pulses[0]), 8'd1);
        chk("t4_sw_key", 8'(key0), 8'hA);

        do_reset();
        frames(kbit(9), 2);
        send(8'h08);
        send(8'h04);
        send(8'h01);
        send(8'h46);
        frames(kbit(9), 1);
        send(8'h00);
        chk("t5_no_count", 8'(pulses[0]), 8'd0);
        frames(kbit(9), 1);
        send(8'h00);
        chk("t5_pulses", 8'(pulses[0]), 8'd1);

        do_reset();
        frames(kbit(9), 3);
        do_reset();
        frames(kbit(9), 3);
        send(8'h00);
        chk("t6_after_rst", 8'(pulses[0]), 8'd0);
        chk("t6_d1_pulses", 8'(pulses[1]), 8'd1);
        chk("t6_d1_key", 8'(key1), 8'h8);
        frames(kbit(9), 1);
        send(8'h00);
        chk("t6_pulses", 8'(pulses[0]), 8'd1);

        do_reset();
        for (int it = 0; it < 300; it++) begin
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 6);
            if (sel <= 2) fm = 16'h0;
            else if (sel <= 7) fm = kbit($urandom_range(0, 15));
            else fm = kbit($urandom_range(0, 15)) | kbit($urandom_range(0, 15));
            if (sel == 9) begin
                send({4'($urandom_range(0, 15)), 4'b1000});
                send({4'($urandom_range(0, 15)), 4'b0100});
                send({4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))});
            end else begin
                frames(fm, hold);
            end
        end
        send(8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
